gate_array_pipe: RTL
====================

# gate_array_pipe

Parametrised, pipelined successor to the single-bit gate primitives. Applies one of eight selectable bitwise logic functions to two WIDTH-bit operands per transaction, with a PIPE-stage registered datapath, valid/ready flow control on both sides, and a wrapping count of accepted transactions. It sits between a producer and a consumer that both use valid/ready streams, and replaces ad-hoc instantiation of individual gate modules.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (legal: ≥1)
- PIPE, 2, number of register stages from input to output (legal: 1..4)
- CNT_W, 16, width of the transaction counter

Ports:
- clk  input  1  single clock for the whole block, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a transaction on a, b, op
- in_ready  output  1  block accepts the transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  function select (encoding under Operation)
- out_valid  output  1  y holds a valid result
- out_ready  input  1  consumer takes the result this cycle
- y  output  WIDTH  result
- txn_count  output  CNT_W  number of accepted input transactions, modulo 2^CNT_W

## Operation

- Op encoding (bitwise across all WIDTH bits): 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 BUF a (b ignored). All eight codes are legal.
- The function is evaluated combinationally on the accepted a, b, op; the result enters stage 1 and then passes through stages 2..PIPE. Each stage holds a data register and a valid bit.
- Global-stall pipeline: advance = !out_valid || out_ready. When advance is 1, every stage loads from its predecessor, and stage 1 loads the new result with valid = in_valid. When advance is 0, every stage holds.
- in_ready = advance. A transfer occurs when in_valid && in_ready, and likewise on the output side.
- Bubbles are not collapsed. An empty stage still takes one advance cycle to pass.
- txn_count increments by 1 on every input transfer and wraps from 2^CNT_W−1 to 0.
- With in_valid low, no state changes except the pipeline advancing. Bubbles shift in.

## Timing

- Reset (asynchronous assert, synchronous release on clk): all stage valid bits are 0, all stage data registers are 0, out_valid = 0, y = 0, and txn_count = 0. in_ready is 1 immediately after reset, because out_valid is 0.
- Latency: an input accepted at edge n appears with out_valid = 1 after edge n+PIPE−1, and can be taken at edge n+PIPE when out_ready is held high.
- Throughput is one transaction per cycle while out_ready stays high.
- When out_valid is high and out_ready is low, in_ready is low in the same cycle (combinational path out_ready → in_ready). y and out_valid stay stable until the output transfer.
- Simultaneous input and output transfer in one cycle is legal. The pipeline shifts by one stage.
- Reset asserted mid-operation discards all in-flight results immediately. No output transfer completes in the reset cycle.
- At PIPE = 1, stage 1 is the output register.

## Structure

- Package gate_pkg holds:
  - the op typedef/enum (3 bits) and named constants for codes 0..7
  - a parametrised function or macro for the bitwise evaluation, shared with any future gate blocks
- One sub-module, gate_alu: purely combinational, parametrised by WIDTH, with inputs a, b, op and output y. gate_array_pipe instantiates it once, in front of stage 1.
- The pipeline stages live in gate_array_pipe as a generate loop over PIPE, not as a separate module.

## Test plan

1. Reset, then all ops, WIDTH=8, PIPE=2, out_ready=1. Drive a=8'hF0, b=8'hCC with op 0..7 on consecutive cycles. Required y sequence, each two cycles after its input: C0, FC, 3F, 03, 3C, C3, 0F, F0. txn_count ends at 8.
2. Backpressure: fill the pipe, then drop out_ready for 5 cycles. in_ready must be low throughout and y/out_valid must hold constant. Raise out_ready and check that every result drains in order with no loss or duplication.
3. Bubbles: toggle in_valid every other cycle with out_ready=1. out_valid must toggle with the same pattern, delayed by PIPE cycles.
4. Counter wrap at CNT_W=4: send 17 transactions. txn_count must read 15 after the 15th, 0 after the 16th, and 1 after the 17th.
5. Mid-stream reset: with 2 valid entries in flight, pulse rst_n low between clock edges. out_valid, y and txn_count must go to 0 immediately, and no stale result may appear afterwards.
6. Parameter sweep over PIPE=1 and PIPE=4 at WIDTH=1 and WIDTH=32, with random stimulus and random out_ready. Compare against a queue-based model for data, order and latency.

Source files
------------

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_pkg
// Brief    : Op encoding and per-bit evaluation shared by the gate blocks.
// Revision : 1.0
// ============================================================================
package gate_pkg;

    localparam int unsigned c_GATE_OP_W = 3;

    typedef enum logic [c_GATE_OP_W-1:0] {
        c_OP_AND   = 3'd0,
        c_OP_OR    = 3'd1,
        c_OP_NAND  = 3'd2,
        c_OP_NOR   = 3'd3,
        c_OP_XOR   = 3'd4,
        c_OP_XNOR  = 3'd5,
        c_OP_NOT_A = 3'd6,
        c_OP_BUF_A = 3'd7
    } gate_op_e;

    // Single-bit evaluation; wider blocks replicate it per bit, so it fits any width.
    function automatic logic gate_eval_bit(input logic a, input logic b, input gate_op_e op);
        logic r;
        r = 1'b0;
        case (op)
            c_OP_AND:   r = a & b;
            c_OP_OR:    r = a | b;
            c_OP_NAND:  r = ~(a & b);
            c_OP_NOR:   r = ~(a | b);
            c_OP_XOR:   r = a ^ b;
            c_OP_XNOR:  r = ~(a ^ b);
            c_OP_NOT_A: r = ~a;
            c_OP_BUF_A: r = a;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_alu.sv
`default_nettype none
// ============================================================================
// Module   : gate_alu
// Brief    : Combinational WIDTH-bit bitwise gate function selected by op.
// Revision : 1.0
// ============================================================================
module gate_alu
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  gate_op_e         op,
    output logic [WIDTH-1:0] y
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign y[g] = gate_eval_bit(a[g], b[g], op);
    end

endmodule
`default_nettype wire

// File: rtl/gate_array_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gate_array_pipe
// Brief    : Pipelined bitwise gate array with valid/ready and txn counter.
// Revision : 1.0
// ============================================================================
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] txn_count
);

    logic [WIDTH-1:0] w_alu_y;
    logic             w_advance;
    logic [WIDTH-1:0] r_data  [PIPE];
    logic             r_valid [PIPE];
    logic [CNT_W-1:0] r_txn_count;

    gate_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (a),
        .b  (b),
        .op (gate_op_e'(op)),
        .y  (w_alu_y)
    );

    // Global stall: the whole chain moves together whenever the output slot can move.
    assign w_advance = !r_valid[PIPE-1] || out_ready;

    for (genvar g = 0; g < PIPE; g++) begin : g_stage
        if (g == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data[g]  <= '0;
                    r_valid[g] <= 1'b0;
                end else if (w_advance) begin
                    r_data[g]  <= w_alu_y;
                    r_valid[g] <= in_valid;
                end
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data[g]  <= '0;
                    r_valid[g] <= 1'b0;
                end else if (w_advance) begin
                    r_data[g]  <= r_data[g-1];
                    r_valid[g] <= r_valid[g-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_count <= '0;
        end else if (in_valid && w_advance) begin
            r_txn_count <= r_txn_count + CNT_W'(1);
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_valid[PIPE-1];
    assign y         = r_data[PIPE-1];
    assign txn_count = r_txn_count;

endmodule
`default_nettype wire
